// File: rtl/dmac_dest_burst_scheduler.sv
// dmac_dest_burst_scheduler: splits destination transfers into 16-beat burst requests under an ID window.
module dmac_dest_burst_scheduler #(
  parameter int C_ID_WIDTH = 3,
  parameter int C_LENGTH_WIDTH = 24
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_aresetn,
  input  logic                      enable,
  output logic                      enabled,
  input  logic                      xfer_valid,
  output logic                      xfer_ready,
  input  logic [C_LENGTH_WIDTH-1:0] xfer_length,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [3:0]                req_last_burst_length,
  output logic                      req_eot,
  output logic [C_ID_WIDTH-1:0]     request_id,
  input  logic [C_ID_WIDTH-1:0]     response_id,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  localparam int CW = C_LENGTH_WIDTH - 4;
  localparam logic [C_ID_WIDTH-1:0] ID_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  state_e state_q, state_d;
  logic enabled_q, enabled_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] last_q, last_d;
  logic [C_ID_WIDTH-1:0] id_q, id_d, id_inc;
  logic win_full, req_hs;
  assign id_inc = id_q + ID_ONE;
  assign win_full = id_inc == response_id;
  assign req_valid = state_q == ISSUE && !win_full;
  assign req_eot = state_q == ISSUE && cnt_q == '0;
  assign req_hs = req_valid && req_ready;
  assign xfer_ready = state_q == IDLE && enable && enabled_q;
  assign busy = state_q == ISSUE;
  assign enabled = enabled_q;
  assign request_id = id_q;
  assign req_last_burst_length = last_q;
  always_comb begin
    state_d = state_q;
    enabled_d = enabled_q;
    cnt_d = cnt_q;
    last_d = last_q;
    id_d = id_q;
    case (state_q)
      IDLE: begin
        if (!enable) state_d = enabled_q ? DRAIN : IDLE;
        else if (!enabled_q) enabled_d = 1'b1;
        else if (xfer_valid) begin
          cnt_d = xfer_length[C_LENGTH_WIDTH-1:4];
          last_d = xfer_length[3:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (req_hs) begin
          id_d = id_inc;
          cnt_d = req_eot ? '0 : cnt_q - CNT_ONE;
          state_d = !enable ? DRAIN : req_eot ? IDLE : ISSUE;
        end else if (!enable && !req_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (response_id == id_q) begin
          state_d = IDLE;
          enabled_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= IDLE;
      enabled_q <= 1'b0;
      cnt_q <= '0;
      last_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      enabled_q <= enabled_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      id_q <= id_d;
    end
  end
endmodule

// File: tb/tb_dmac_dest_burst_scheduler.sv
// tb_dmac_dest_burst_scheduler: directed scoreboard bench for the destination burst scheduler.
module tb_dmac_dest_burst_scheduler;
  localparam int IW = 3;
  localparam int LW = 24;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic xfer_valid = 1'b0;
  logic req_ready = 1'b0;
  logic [LW-1:0] xfer_length = '0;
  logic [IW-1:0] response_id = '0;
  logic enabled, xfer_ready, req_valid, req_eot, busy;
  logic [3:0] req_last_burst_length;
  logic [IW-1:0] request_id;
  typedef struct packed {
    logic [IW-1:0] id;
    logic eot;
    logic [3:0] len;
  } burst_t;
  burst_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  int popped = 0;
  int cyc;
  logic [IW-1:0] push_id = '0;
  logic [IW-1:0] model_id = '0;
  bit track = 1'b0;
  dmac_dest_burst_scheduler #(.C_ID_WIDTH(IW), .C_LENGTH_WIDTH(LW)) dut (
    .s_axis_aclk(clk),
    .s_axis_aresetn(rst_n),
    .enable(enable),
    .enabled(enabled),
    .xfer_valid(xfer_valid),
    .xfer_ready(xfer_ready),
    .xfer_length(xfer_length),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_last_burst_length(req_last_burst_length),
    .req_eot(req_eot),
    .request_id(request_id),
    .response_id(response_id),
    .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    burst_t b;
    @(negedge clk);
    if (req_valid && req_ready) begin
      chk("burst_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        b = sb.pop_front();
        chk("burst_id", 32'(request_id), 32'(b.id));
        chk("burst_eot", 32'(req_eot), 32'(b.eot));
        chk("burst_len", 32'(req_last_burst_length), 32'(b.len));
        popped++;
      end
      model_id++;
    end
    @(posedge clk);
    #1;
    if (track) response_id = model_id;
  endtask
  task automatic do_xfer(input logic [LW-1:0] len);
    int n;
    n = int'(len >> 4) + 1;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{id: push_id, eot: 1'(i == n - 1), len: len[3:0]});
      push_id++;
    end
    xfer_length = len;
    xfer_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (xfer_ready) break;
    end
    chk("xfer_accept", 32'(xfer_ready), 1);
    @(posedge clk);
    #1;
    xfer_valid = 1'b0;
  endtask
  task automatic run_until_empty(input int budget, output int cycles);
    cycles = 0;
    while (sb.size() != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("queue_drained", 32'(sb.size()), 0);
  endtask
  task automatic chk_reset_values();
    chk("rst_enabled", 32'(enabled), 0);
    chk("rst_xfer_ready", 32'(xfer_ready), 0);
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_req_eot", 32'(req_eot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_last_len", 32'(req_last_burst_length), 0);
    chk("rst_request_id", 32'(request_id), 0);
  endtask
  initial begin
    #2;
    chk_reset_values();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    enable = 1'b1;
    chk("enabled_before_rise", 32'(enabled), 0);
    tick();
    chk("enabled_rise", 32'(enabled), 1);
    chk("xfer_ready_idle", 32'(xfer_ready), 1);
    track = 1'b1;
    req_ready = 1'b1;
    do_xfer(24'h3F);
    chk("busy_issue", 32'(busy), 1);
    run_until_empty(20, cyc);
    chk("b2b_cycles_3f", 32'(cyc), 4);
    chk("request_id_after_3f", 32'(request_id), 4);
    chk("xfer_ready_after_eot", 32'(xfer_ready), 1);
    chk("busy_after_eot", 32'(busy), 0);
    do_xfer(24'h12);
    run_until_empty(20, cyc);
    chk("b2b_cycles_12", 32'(cyc), 2);
    do_xfer(24'h0);
    run_until_empty(20, cyc);
    chk("cycles_len0", 32'(cyc), 1);
    chk("request_id_after_len0", 32'(request_id), 7);
    track = 1'b0;
    response_id = 3'd7;
    do_xfer(24'hFF);
    popped = 0;
    repeat (12) tick();
    chk("window_bursts", 32'(popped), 7);
    chk("window_full_valid", 32'(req_valid), 0);
    chk("window_full_id", 32'(request_id), 6);
    chk("window_full_busy", 32'(busy), 1);
    response_id = 3'd0;
    popped = 0;
    repeat (4) tick();
    chk("window_one_more", 32'(popped), 1);
    chk("window_wrap_id", 32'(request_id), 7);
    chk("window_full_again", 32'(req_valid), 0);
    track = 1'b1;
    response_id = model_id;
    run_until_empty(20, cyc);
    chk("window_rest_cycles", 32'(cyc), 8);
    chk("request_id_after_ff", 32'(request_id), 7);
    track = 1'b0;
    req_ready = 1'b0;
    do_xfer(24'h3F);
    tick();
    chk("stall_valid", 32'(req_valid), 1);
    chk("stall_eot", 32'(req_eot), 0);
    chk("stall_id", 32'(request_id), 7);
    enable = 1'b0;
    repeat (3) tick();
    chk("hold_valid", 32'(req_valid), 1);
    chk("hold_id", 32'(request_id), 7);
    chk("hold_eot", 32'(req_eot), 0);
    chk("hold_busy", 32'(busy), 1);
    req_ready = 1'b1;
    popped = 0;
    tick();
    chk("abort_one_burst", 32'(popped), 1);
    chk("drain_valid", 32'(req_valid), 0);
    chk("drain_busy", 32'(busy), 0);
    chk("drain_xfer_ready", 32'(xfer_ready), 0);
    chk("drain_enabled", 32'(enabled), 1);
    chk("drain_id", 32'(request_id), 0);
    sb.delete();
    push_id = model_id;
    tick();
    chk("drain_wait_enabled", 32'(enabled), 1);
    chk("drain_wait_valid", 32'(req_valid), 0);
    response_id = 3'd0;
    chk("drain_match_enabled", 32'(enabled), 1);
    tick();
    chk("drain_done_enabled", 32'(enabled), 0);
    enable = 1'b1;
    tick();
    chk("reenable", 32'(enabled), 1);
    req_ready = 1'b1;
    do_xfer(24'h3F);
    tick();
    req_ready = 1'b0;
    chk("pre_reset_id", 32'(request_id), 1);
    chk("pre_reset_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    sb.delete();
    push_id = '0;
    model_id = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_reset_enabled", 32'(enabled), 1);
    chk("post_reset_id", 32'(request_id), 0);
    chk("post_reset_xfer_ready", 32'(xfer_ready), 1);
    chk("post_reset_busy", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
